control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows:
  - Clock  in  1  rising-edge clock
  - clear  in  1  asynchronous active-low reset
REQ-002 The block SHALL have these inputs:
  - irOut  in  32  current IR contents; opcode [31:27], ra [26:23], rb [22:19], rc [18:15], C [18:0]
  - branchCompare  in  1  CON result from the datapath
  - Stop  in  1  halt request
REQ-003 The block SHALL have these outputs:
  - Rin, Rout  out  16 each  one-hot register strobes, selecting R[ra]/R[rb]/R[rc]
  - BAOut  out  1  base-address mode: R0 reads as 0
  - PCout, PCin, InPC, MARin, MDRin, MDRout, Read, Write  out  1 each
  - Yin, Zin, Zlowout, IRin, CONin, InPortout, OutPortin  out  1 each
  - Cout  out  1  drive C_sext onto the bus
  - C_sext  out  32  C sign-extended from bit 18
  - op  out  5  ALU operation code
  - Run  out  1  high while executing

Function
REQ-004 Opcodes SHALL be: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, br=10010, in=10110, out=10111, nop=11000, halt=11001.
REQ-005 Any other opcode SHALL execute as nop.
REQ-006 The FSM SHALL have the states RESET, T0-T7 and HALT, and SHALL advance one state per rising Clock edge.
REQ-007 Outputs SHALL be decoded combinationally from the state register and irOut only.
REQ-008 Fetch states SHALL assert:
  - T0: PCout, MARin, InPC, Zin, op=00011
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
REQ-009 add/sub/and/or SHALL assert:
  - T3: Rout[rb], Yin
  - T4: Rout[rc], Zin, op=opcode
  - T5: Zlowout, Rin[ra]
  - then go to T0
REQ-010 ldi SHALL assert:
  - T3: Rout[rb], BAOut, Yin
  - T4: Cout, Zin, op=00011
  - T5: Zlowout, Rin[ra]
  - then go to T0
REQ-011 ld SHALL use the ldi T3-T4 sequence, then:
  - T5: Zlowout, MARin
  - T6: Read, MDRin
  - T7: MDRout, Rin[ra]
  - then go to T0
REQ-012 st SHALL use T3-T5 as for ld, then:
  - T6: Rout[ra], MDRin
  - T7: Write
  - then go to T0
REQ-013 br SHALL assert:
  - T3: Rout[ra], CONin
  - T4: PCout, Yin
  - T5: Cout, Zin, op=00011
  - T6: Zlowout, plus PCin only if branchCompare=1
  - then go to T0
REQ-014 in SHALL assert InPortout and Rin[ra] in T3, then go to T0; out SHALL assert Rout[ra] and OutPortin in T3, then go to T0.
REQ-015 nop SHALL go from T2 directly to T0.
REQ-016 halt SHALL go from T2 to HALT.
REQ-017 If Stop=1 on the edge leaving T2, the FSM SHALL enter HALT instead of T3, so the fetched instruction is discarded.
REQ-018 HALT SHALL hold all strobes at 0 and Run=0 until clear is asserted.
REQ-019 Run SHALL be 1 in T0-T7 and 0 in RESET and HALT.
REQ-020 At most one bit of Rin and one bit of Rout SHALL be set in any state.
REQ-021 Unused outputs SHALL be 0 in every state; op SHALL be 00000 when no ALU operation is requested.

Reset
REQ-022 clear=0 SHALL force RESET immediately, from any state including mid-instruction, and SHALL drive all outputs to 0, with C_sext following irOut.
REQ-023 The first rising Clock edge with clear=1 SHALL move RESET to T0.

Configuration
REQ-024 With CU_MEM_WAIT_EN defined, the block SHALL add input mem_ready (1 bit) and hold T1, ld-T6 and st-T7 with Read/Write asserted until mem_ready=1 is sampled.
REQ-025 clear SHALL still override the REQ-024 wait immediately.
REQ-026 Without CU_MEM_WAIT_EN, the mem_ready port SHALL be absent and each memory state SHALL last exactly one cycle.

Verification
REQ-027 The bench SHALL cover these scenarios:
  - add, irOut=0x18910000 (ra=1, rb=2, rc=2): T3 Rout=0x0004; T4 op=00011; T5 Rin=0x0002; 6 cycles in total.
  - ldi, irOut=0x08800005 (ra=1, rb=0, C=5): T3 BAOut=1; C_sext=0x00000005; T5 Rin=0x0002; return to T0.
  - br, irOut=0x9107FFFF (C=-1): C_sext=0xFFFFFFFF; T6 PCin=1 with branchCompare=1 and 0 with branchCompare=0.
  - halt opcode, then Stop=1 during T2 of a subsequent run: HALT is entered, Run=0, and it stays there 10 cycles.
  - clear=0 asserted in ld T6: all outputs are 0 without waiting for a clock edge; T0 follows release.
  - With CU_MEM_WAIT_EN and mem_ready low for 3 cycles in T1: Read stays high 4 cycles, then T2.

Source files
------------

// File: rtl/control_unit.sv
// control_unit -- hardwired control sequencer for a small load/store CPU.
//
// Runs a fetch (T0-T2) followed by an opcode-specific execute sequence
// (T3-T7). Every control strobe is decoded combinationally from the
// state register and irOut.
//
// Ports:
//   Clock, clear          rising-edge clock, asynchronous active-low reset
//   irOut[31:0]           IR contents: opcode[31:27] ra[26:23] rb[22:19]
//                         rc[18:15] C[18:0]
//   branchCompare         CON flag from the datapath, gates PCin in br T6
//   Stop                  halt request, sampled on the edge leaving T2
//   Rin/Rout[15:0]        one-hot register-file strobes
//   BAOut .. Cout         single-bit datapath strobes
//   C_sext[31:0]          C sign-extended from bit 18
//   op[4:0]               ALU operation (0 when the ALU is idle)
//   Run                   high while an instruction is executing
//
// Optional feature: define CU_MEM_WAIT_EN to add a mem_ready input.
// T1, ld-T6 and st-T7 then hold with Read/Write asserted until
// mem_ready=1 is sampled.
module control_unit (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] irOut,
   input  logic        branchCompare,
   input  logic        Stop,
`ifdef CU_MEM_WAIT_EN
   input  logic        mem_ready,
`endif
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        BAOut,
   output logic        PCout, PCin, InPC, MARin, MDRin, MDRout, Read, Write,
   output logic        Yin, Zin, Zlowout, IRin, CONin, InPortout, OutPortin,
   output logic        Cout,
   output logic [31:0] C_sext,
   output logic [4:0]  op,
   output logic        Run
);

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001,
                          OP_ST   = 5'b00010, OP_ADD  = 5'b00011,
                          OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                          OP_OR   = 5'b00110, OP_BR   = 5'b10010,
                          OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                          OP_HALT = 5'b11001;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   state_t r_state, w_next;

   logic [4:0]  w_opc;
   logic        w_alu, w_ldi, w_ld, w_st, w_br, w_in, w_out, w_halt;
   logic        w_mem_ready;
   logic [15:0] w_ra_oh, w_rb_oh, w_rc_oh;

`ifdef CU_MEM_WAIT_EN
   assign w_mem_ready = mem_ready;
`else
   assign w_mem_ready = 1'b1;
`endif

   assign w_opc  = irOut[31:27];
   assign w_alu  = (w_opc == OP_ADD) || (w_opc == OP_SUB) ||
                   (w_opc == OP_AND) || (w_opc == OP_OR);
   assign w_ldi  = (w_opc == OP_LDI);
   assign w_ld   = (w_opc == OP_LD);
   assign w_st   = (w_opc == OP_ST);
   assign w_br   = (w_opc == OP_BR);
   assign w_in   = (w_opc == OP_IN);
   assign w_out  = (w_opc == OP_OUT);
   assign w_halt = (w_opc == OP_HALT);
   // nop and every unlisted opcode fall through all the flags above

   assign w_ra_oh = 16'h0001 << irOut[26:23];
   assign w_rb_oh = 16'h0001 << irOut[22:19];
   assign w_rc_oh = 16'h0001 << irOut[18:15];

   assign C_sext = {{13{irOut[18]}}, irOut[18:0]};

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) r_state <= S_RESET;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RESET: w_next = S_T0;
         S_T0:    w_next = S_T1;
         S_T1:    w_next = w_mem_ready ? S_T2 : S_T1;
         S_T2: begin
            // Stop wins over the decoded opcode: the fetched word is dropped
            if (Stop || w_halt)                   w_next = S_HALT;
            else if (w_alu || w_ldi || w_ld || w_st ||
                     w_br || w_in || w_out)       w_next = S_T3;
            else                                  w_next = S_T0;
         end
         S_T3:    w_next = (w_in || w_out) ? S_T0 : S_T4;
         S_T4:    w_next = S_T5;
         S_T5:    w_next = (w_ld || w_st || w_br) ? S_T6 : S_T0;
         S_T6: begin
            if (w_br)                      w_next = S_T0;
            else if (w_ld && !w_mem_ready) w_next = S_T6;
            else                           w_next = S_T7;
         end
         S_T7:    w_next = (w_st && !w_mem_ready) ? S_T7 : S_T0;
         S_HALT:  w_next = S_HALT;
         default: w_next = S_RESET;
      endcase
   end

   always_comb begin
      Rin = '0; Rout = '0; BAOut = 1'b0;
      PCout = 1'b0; PCin = 1'b0; InPC = 1'b0; MARin = 1'b0;
      MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
      Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; IRin = 1'b0;
      CONin = 1'b0; InPortout = 1'b0; OutPortin = 1'b0; Cout = 1'b0;
      op = 5'b00000; Run = 1'b0;
      case (r_state)
         S_T0: begin
            Run = 1'b1; PCout = 1'b1; MARin = 1'b1; InPC = 1'b1;
            Zin = 1'b1; op = OP_ADD;
         end
         S_T1: begin
            Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            Run = 1'b1;
            if (w_alu) begin
               Rout = w_rb_oh; Yin = 1'b1;
            end else if (w_ldi || w_ld || w_st) begin
               // R0 reads as zero here, giving absolute addressing for rb=0
               Rout = w_rb_oh; BAOut = 1'b1; Yin = 1'b1;
            end else if (w_br) begin
               Rout = w_ra_oh; CONin = 1'b1;
            end else if (w_in) begin
               InPortout = 1'b1; Rin = w_ra_oh;
            end else if (w_out) begin
               Rout = w_ra_oh; OutPortin = 1'b1;
            end
         end
         S_T4: begin
            Run = 1'b1;
            if (w_alu) begin
               Rout = w_rc_oh; Zin = 1'b1; op = w_opc;
            end else if (w_ldi || w_ld || w_st) begin
               Cout = 1'b1; Zin = 1'b1; op = OP_ADD;
            end else if (w_br) begin
               PCout = 1'b1; Yin = 1'b1;
            end
         end
         S_T5: begin
            Run = 1'b1;
            if (w_alu || w_ldi) begin
               Zlowout = 1'b1; Rin = w_ra_oh;
            end else if (w_ld || w_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (w_br) begin
               Cout = 1'b1; Zin = 1'b1; op = OP_ADD;
            end
         end
         S_T6: begin
            Run = 1'b1;
            if (w_ld) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (w_st) begin
               Rout = w_ra_oh; MDRin = 1'b1;
            end else if (w_br) begin
               Zlowout = 1'b1; PCin = branchCompare;
            end
         end
         S_T7: begin
            Run = 1'b1;
            if (w_ld) begin
               MDRout = 1'b1; Rin = w_ra_oh;
            end else if (w_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process pushes expected
// values tagged with the cycle they apply to; the monitor samples on the
// falling edge and pops/compares every entry due in that cycle.
module tb_control_unit;

   logic        Clock, clear, branchCompare, Stop;
   logic [31:0] irOut;
   logic [15:0] Rin, Rout;
   logic        BAOut, PCout, PCin, InPC, MARin, MDRin, MDRout, Read, Write;
   logic        Yin, Zin, Zlowout, IRin, CONin, InPortout, OutPortin, Cout;
   logic [31:0] C_sext;
   logic [4:0]  op;
   logic        Run;
`ifdef CU_MEM_WAIT_EN
   logic        mem_ready;
`endif

   control_unit dut (
      .Clock(Clock), .clear(clear), .irOut(irOut),
      .branchCompare(branchCompare), .Stop(Stop),
`ifdef CU_MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .Rin(Rin), .Rout(Rout), .BAOut(BAOut),
      .PCout(PCout), .PCin(PCin), .InPC(InPC), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
      .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .IRin(IRin), .CONin(CONin),
      .InPortout(InPortout), .OutPortin(OutPortin), .Cout(Cout),
      .C_sext(C_sext), .op(op), .Run(Run)
   );

   // strobe word bit positions
   localparam logic [16:0] C_BAO  = 17'h10000, C_PCOUT = 17'h08000,
                           C_PCIN = 17'h04000, C_INPC  = 17'h02000,
                           C_MARIN= 17'h01000, C_MDRIN = 17'h00800,
                           C_MDROUT=17'h00400, C_READ  = 17'h00200,
                           C_WRITE= 17'h00100, C_YIN   = 17'h00080,
                           C_ZIN  = 17'h00040, C_ZLOW  = 17'h00020,
                           C_IRIN = 17'h00010, C_CONIN = 17'h00008,
                           C_INPO = 17'h00004, C_OUTPI = 17'h00002,
                           C_COUT = 17'h00001;

   localparam logic [31:0] I_ADD = 32'h18910000, I_LDI = 32'h08800005,
                           I_BR  = 32'h9107FFFF, I_LD  = 32'h00800005,
                           I_ST  = 32'h10800005, I_IN  = 32'hB0800000,
                           I_OUT = 32'hB8800000, I_NOP = 32'hC0000000,
                           I_UNK = 32'h38000000, I_HALT= 32'hC8000000;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always @(posedge Clock) cyc <= cyc + 1;

   function automatic logic [31:0] sig(int s);
      case (s)
         0: sig = {15'b0, BAOut, PCout, PCin, InPC, MARin, MDRin, MDRout, Read,
                   Write, Yin, Zin, Zlowout, IRin, CONin, InPortout, OutPortin, Cout};
         1: sig = {16'b0, Rin};
         2: sig = {16'b0, Rout};
         3: sig = {27'b0, op};
         4: sig = C_sext;
         default: sig = {31'b0, Run};
      endcase
   endfunction

   // monitor
   always @(negedge Clock) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] a;
         e = q.pop_front();
         n_cmp++;
         a = sig(e.sel);
         if (e.cyc < cyc) begin
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
         end else if (a !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, a, e.exp);
         end
      end
   end

   task automatic push(int c, int s, logic [31:0] v, string n);
      exp_t e;
      e.cyc = c; e.sel = s; e.exp = v; e.name = $sformatf("c%0d.%s", c, n);
      q.push_back(e);
   endtask

   task automatic ex_st(int c, logic [16:0] ctl, logic [15:0] rin, logic [15:0] rout,
                        logic [4:0] opv, logic run, string n);
      push(c, 0, {15'b0, ctl}, {n, ".strobes"});
      push(c, 1, {16'b0, rin}, {n, ".Rin"});
      push(c, 2, {16'b0, rout}, {n, ".Rout"});
      push(c, 3, {27'b0, opv}, {n, ".op"});
      push(c, 5, {31'b0, run}, {n, ".Run"});
   endtask

   task automatic fetch(int c);
      ex_st(c,     C_PCOUT | C_MARIN | C_INPC | C_ZIN, 0, 0, 5'd3, 1'b1, "T0");
      ex_st(c + 1, C_ZLOW | C_PCIN | C_READ | C_MDRIN, 0, 0, 5'd0, 1'b1, "T1");
      ex_st(c + 2, C_MDROUT | C_IRIN, 0, 0, 5'd0, 1'b1, "T2");
   endtask

   task automatic go(int c);
      while (cyc < c) begin
         @(posedge Clock);
         #1;
      end
   endtask

   initial begin
      int c;
      clear = 1'b0; Stop = 1'b0; branchCompare = 1'b0; irOut = I_ADD;
`ifdef CU_MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      // reset state, clear held through the first edge
      ex_st(1, 0, 0, 0, 0, 1'b0, "reset");
      push(1, 4, 32'h00010000, "reset.C_sext");
      go(1); clear = 1'b1;
      c = 2;

      // add: 6 cycles, next T0 proves the return
      fetch(c);
      ex_st(c + 3, C_YIN, 0, 16'h0004, 0, 1'b1, "add.T3");
      ex_st(c + 4, C_ZIN, 0, 16'h0004, 5'd3, 1'b1, "add.T4");
      ex_st(c + 5, C_ZLOW, 16'h0002, 0, 0, 1'b1, "add.T5");
      c += 6;

      // ldi
      go(c); irOut = I_LDI;
      push(c, 4, 32'h00000005, "ldi.C_sext");
      fetch(c);
      ex_st(c + 3, C_BAO | C_YIN, 0, 16'h0001, 0, 1'b1, "ldi.T3");
      ex_st(c + 4, C_COUT | C_ZIN, 0, 0, 5'd3, 1'b1, "ldi.T4");
      ex_st(c + 5, C_ZLOW, 16'h0002, 0, 0, 1'b1, "ldi.T5");
      c += 6;

      // br taken
      go(c); irOut = I_BR; branchCompare = 1'b1;
      push(c, 4, 32'hFFFFFFFF, "br.C_sext");
      fetch(c);
      ex_st(c + 3, C_CONIN, 0, 16'h0004, 0, 1'b1, "br.T3");
      ex_st(c + 4, C_PCOUT | C_YIN, 0, 0, 0, 1'b1, "br.T4");
      ex_st(c + 5, C_COUT | C_ZIN, 0, 0, 5'd3, 1'b1, "br.T5");
      ex_st(c + 6, C_ZLOW | C_PCIN, 0, 0, 0, 1'b1, "br1.T6");
      c += 7;

      // br not taken
      go(c); branchCompare = 1'b0;
      fetch(c);
      ex_st(c + 6, C_ZLOW, 0, 0, 0, 1'b1, "br0.T6");
      c += 7;

      // ld full sequence
      go(c); irOut = I_LD;
      fetch(c);
      ex_st(c + 3, C_BAO | C_YIN, 0, 16'h0001, 0, 1'b1, "ld.T3");
      ex_st(c + 4, C_COUT | C_ZIN, 0, 0, 5'd3, 1'b1, "ld.T4");
      ex_st(c + 5, C_ZLOW | C_MARIN, 0, 0, 0, 1'b1, "ld.T5");
      ex_st(c + 6, C_READ | C_MDRIN, 0, 0, 0, 1'b1, "ld.T6");
      ex_st(c + 7, C_MDROUT, 16'h0002, 0, 0, 1'b1, "ld.T7");
      c += 8;

      // ld interrupted by clear in T6 (asserted between edges)
      fetch(c);
      ex_st(c + 5, C_ZLOW | C_MARIN, 0, 0, 0, 1'b1, "ldc.T5");
      ex_st(c + 6, 0, 0, 0, 0, 1'b0, "ldc.clear");
      push(c + 6, 4, 32'h00000005, "ldc.C_sext");
      ex_st(c + 7, 0, 0, 0, 0, 1'b0, "ldc.reset");
      go(c + 6); clear = 1'b0;
      go(c + 7); clear = 1'b1;
      c += 8;

      // st
      go(c); irOut = I_ST;
      fetch(c);
      ex_st(c + 3, C_BAO | C_YIN, 0, 16'h0001, 0, 1'b1, "st.T3");
      ex_st(c + 4, C_COUT | C_ZIN, 0, 0, 5'd3, 1'b1, "st.T4");
      ex_st(c + 5, C_ZLOW | C_MARIN, 0, 0, 0, 1'b1, "st.T5");
      ex_st(c + 6, C_MDRIN, 0, 16'h0002, 0, 1'b1, "st.T6");
      ex_st(c + 7, C_WRITE, 0, 0, 0, 1'b1, "st.T7");
      c += 8;

      // in / out
      go(c); irOut = I_IN;
      fetch(c);
      ex_st(c + 3, C_INPO, 16'h0002, 0, 0, 1'b1, "in.T3");
      c += 4;
      go(c); irOut = I_OUT;
      fetch(c);
      ex_st(c + 3, C_OUTPI, 0, 16'h0002, 0, 1'b1, "out.T3");
      c += 4;

      // nop and an unlisted opcode both return from T2
      go(c); irOut = I_NOP;
      fetch(c);
      c += 3;
      go(c); irOut = I_UNK;
      fetch(c);
      c += 3;

      // halt opcode: HALT for 10 cycles, then clear
      go(c); irOut = I_HALT;
      fetch(c);
      for (int k = 3; k <= 12; k++) ex_st(c + k, 0, 0, 0, 0, 1'b0, "halt");
      go(c + 12); clear = 1'b0;
      go(c + 13); clear = 1'b1; irOut = I_ADD;
      c += 14;

      // Stop during T2 discards the fetched add
      fetch(c);
      for (int k = 3; k <= 12; k++) ex_st(c + k, 0, 0, 0, 0, 1'b0, "stop");
      go(c + 2); Stop = 1'b1;
      go(c + 3); Stop = 1'b0;
      go(c + 12); clear = 1'b0;
      go(c + 13); clear = 1'b1;
      c += 14;

`ifdef CU_MEM_WAIT_EN
      // T1 stretched by three low mem_ready samples
      go(c); mem_ready = 1'b0;
      ex_st(c, C_PCOUT | C_MARIN | C_INPC | C_ZIN, 0, 0, 5'd3, 1'b1, "mw.T0");
      for (int k = 1; k <= 4; k++)
         ex_st(c + k, C_ZLOW | C_PCIN | C_READ | C_MDRIN, 0, 0, 0, 1'b1, "mw.T1");
      ex_st(c + 5, C_MDROUT | C_IRIN, 0, 0, 0, 1'b1, "mw.T2");
      ex_st(c + 6, C_YIN, 0, 16'h0004, 0, 1'b1, "mw.T3");
      go(c + 4); mem_ready = 1'b1;
      c += 7;
`endif

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge Clock);
      @(negedge Clock);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL %s: never checked, expected 0x%08h", e.name, e.exp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
